interrupt_ctrl_8051: RTL and testbench

- Interrupt controller for the 8051 core. It sits directly downstream of the timer block and the other peripheral flag sources.
- Latches requests from five sources, masks them with IE, and resolves priority with IP and fixed in-level order.
- Tracks nesting through two in-service levels.
- Hands one vector at a time to the CPU with a request/acknowledge handshake.

---
 rtl/interrupt_ctrl_8051.sv | 144 ++++++++++++++
 tb/tb_interrupt_ctrl_8051.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ctrl_8051.sv
// 8051 interrupt controller: latches five request sources, masks with IE/EA,
// resolves two priority levels and hands one vector at a time to the CPU.
module interrupt_ctrl_8051 #(
  parameter int         NSRC     = 5,
  parameter logic [7:0] VEC_BASE = 8'h03
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            set_IE,
  input  logic            set_IP,
  input  logic [7:0]      ram_rd_byte,
  input  logic [NSRC-1:0] int_src,
  input  logic            inst_boundary,
  input  logic            int_ack,
  input  logic            reti,
  output logic            int_pending,
  output logic [7:0]      int_vector,
  output logic [NSRC-1:0] src_clear,
  output logic [7:0]      ie_out,
  output logic [7:0]      ip_out
);

  localparam int              IW      = $clog2(NSRC);
  localparam int              NEDGE   = NSRC - 1;  // top source is level-sensitive
  localparam logic [NSRC-1:0] SRC_ONE = NSRC'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [7:0]       ie_q;
  logic [7:0]       ip_q;
  logic [NEDGE-1:0] src_q;
  logic [NSRC-1:0]  pend;
  logic [0:0]       state;
  logic [IW-1:0]    idx_q;
  logic             lvl_q;
  logic [7:0]       vec_q;
  logic             in_service_hi;
  logic             in_service_lo;

  logic             ea;
  logic [NSRC-1:0]  elig;
  logic [NSRC-1:0]  hi_cand;
  logic [NSRC-1:0]  lo_cand;
  logic             hi_ok;
  logic             lo_ok;
  logic             grant;
  logic             ack_go;
  logic [NSRC-1:0]  clr_mask;
  logic [NEDGE-1:0] edge_det;
  logic [IW-1:0]    hi_idx;
  logic [IW-1:0]    lo_idx;
  logic [IW-1:0]    win_idx;
  logic             win_lvl;
  logic [7:0]       win_off;
  logic             isr_hi_next;
  logic             isr_lo_next;

  assign ea       = ie_q[7];
  assign elig     = pend & ie_q[NSRC-1:0] & {NSRC{ea}};
  assign hi_cand  = elig & ip_q[NSRC-1:0];
  assign lo_cand  = elig & ~ip_q[NSRC-1:0];
  assign hi_ok    = !in_service_hi && (|hi_cand);
  assign lo_ok    = !in_service_hi && !in_service_lo && (|lo_cand);
  assign grant    = (state == IDLE) && inst_boundary && (hi_ok || lo_ok);
  assign ack_go   = (state == REQ) && int_ack;
  assign clr_mask = ack_go ? (SRC_ONE << idx_q) : '0;
  assign edge_det = int_src[NEDGE-1:0] & ~src_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (hi_cand[i]) hi_idx = IW'(i);
      if (lo_cand[i]) lo_idx = IW'(i);
    end
    win_lvl = hi_ok;
    win_idx = hi_ok ? hi_idx : lo_idx;
    win_off = {{(8 - IW - 3){1'b0}}, win_idx, 3'b000};
  end

  // A RETI retires the innermost level before an ack in the same cycle sets one.
  always_comb begin
    isr_hi_next = in_service_hi;
    isr_lo_next = in_service_lo;
    if (reti) begin
      if (in_service_hi) isr_hi_next = 1'b0;
      else               isr_lo_next = 1'b0;
    end
    if (ack_go) begin
      if (lvl_q) isr_hi_next = 1'b1;
      else       isr_lo_next = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values seen before the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ie_q          <= '0;
      ip_q          <= '0;
      src_q         <= '0;
      pend          <= '0;
      state         <= IDLE;
      idx_q         <= '0;
      lvl_q         <= 1'b0;
      vec_q         <= '0;
      in_service_hi <= 1'b0;
      in_service_lo <= 1'b0;
      src_clear     <= '0;
    end else begin
      if (set_IE) ie_q <= ram_rd_byte;
      if (set_IP) ip_q <= ram_rd_byte;
      src_q             <= int_src[NEDGE-1:0];
      // An edge arriving with the service clear keeps the flag set.
      pend[NEDGE-1:0]   <= (pend[NEDGE-1:0] & ~clr_mask[NEDGE-1:0]) | edge_det;
      pend[NSRC-1]      <= int_src[NSRC-1];
      in_service_hi     <= isr_hi_next;
      in_service_lo     <= isr_lo_next;
      src_clear         <= clr_mask;
      case (state)
        IDLE: if (grant) begin
          state <= REQ;
          idx_q <= win_idx;
          lvl_q <= win_lvl;
          vec_q <= VEC_BASE + win_off;
        end
        REQ: if (int_ack) begin
          state <= IDLE;
          vec_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign int_pending = (state == REQ);
  assign int_vector  = vec_q;
  assign ie_out      = ie_q;
  assign ip_out      = ip_q;

endmodule

// File: tb/tb_interrupt_ctrl_8051.sv
// Self-checking bench for interrupt_ctrl_8051: expected vectors and source
// clears are queued when requests are stimulated and checked at service time.
module tb_interrupt_ctrl_8051;

  logic       clock = 1'b0;
  logic       reset;
  logic       set_IE;
  logic       set_IP;
  logic [7:0] ram_rd_byte;
  logic [4:0] int_src;
  logic       inst_boundary;
  logic       int_ack;
  logic       reti;
  logic       int_pending;
  logic [7:0] int_vector;
  logic [4:0] src_clear;
  logic [7:0] ie_out;
  logic [7:0] ip_out;

  typedef struct packed {
    logic [7:0] vec;
    logic [4:0] clr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  interrupt_ctrl_8051 dut (
    .clock        (clock),
    .reset        (reset),
    .set_IE       (set_IE),
    .set_IP       (set_IP),
    .ram_rd_byte  (ram_rd_byte),
    .int_src      (int_src),
    .inst_boundary(inst_boundary),
    .int_ack      (int_ack),
    .reti         (reti),
    .int_pending  (int_pending),
    .int_vector   (int_vector),
    .src_clear    (src_clear),
    .ie_out       (ie_out),
    .ip_out       (ip_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_ie(input logic [7:0] v);
    ram_rd_byte = v; set_IE = 1'b1;
    tick();
    set_IE = 1'b0;
  endtask

  task automatic write_ip(input logic [7:0] v);
    ram_rd_byte = v; set_IP = 1'b1;
    tick();
    set_IP = 1'b0;
  endtask

  task automatic pulse(input logic [4:0] mask);
    int_src = mask;
    tick();
    int_src = 5'b0;
  endtask

  task automatic do_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  task automatic expect_vec(input logic [7:0] vec, input logic [4:0] clr);
    exp_t e;
    e.vec = vec;
    e.clr = clr;
    sb.push_back(e);
  endtask

  task automatic wait_pending(input string name);
    for (int i = 0; i < 20 && !int_pending; i++) tick();
    checks++;
    if (int_pending !== 1'b1) begin
      errors++;
      $display("FAIL %s: int_pending timeout, got %b want 1", name, int_pending);
    end
  endtask

  task automatic service(input string name);
    exp_t e;
    wait_pending(name);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: request with empty scoreboard, vector %h", name, int_vector);
      return;
    end
    e = sb.pop_front();
    if (int_vector !== e.vec) begin
      errors++;
      $display("FAIL %s vector: got %h want %h", name, int_vector, e.vec);
    end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++;
    if (int_pending !== 1'b0) begin
      errors++;
      $display("FAIL %s drop: int_pending got %b want 0", name, int_pending);
    end
    checks++;
    if (src_clear !== e.clr) begin
      errors++;
      $display("FAIL %s src_clear: got %b want %b", name, src_clear, e.clr);
    end
    tick();
    checks++;
    if (src_clear !== 5'b0) begin
      errors++;
      $display("FAIL %s src_clear pulse: got %b want 00000", name, src_clear);
    end
  endtask

  task automatic no_request(input string name, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (int_pending) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL %s: unexpected int_pending, vector %h", name, int_vector);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; set_IE = 1'b0; set_IP = 1'b0; ram_rd_byte = 8'h00;
    int_src = 5'b0; inst_boundary = 1'b1; int_ack = 1'b0; reti = 1'b0;
    tick(); tick();
    checks++;
    if ({int_pending, int_vector, src_clear, ie_out, ip_out} !== 30'b0) begin
      errors++;
      $display("FAIL reset outputs: got %b %h %b %h %h want all zero",
               int_pending, int_vector, src_clear, ie_out, ip_out);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_regs();
    ram_rd_byte = 8'hE5; set_IE = 1'b1; set_IP = 1'b1;
    tick();
    set_IE = 1'b0; set_IP = 1'b0;
    checks++;
    if (ie_out !== 8'hE5 || ip_out !== 8'hE5) begin
      errors++;
      $display("FAIL regs both: ie %h ip %h want e5 e5", ie_out, ip_out);
    end
    write_ip(8'h00);
    write_ie(8'h00);
    checks++;
    if (ie_out !== 8'h00 || ip_out !== 8'h00) begin
      errors++;
      $display("FAIL regs clear: ie %h ip %h want 00 00", ie_out, ip_out);
    end
  endtask

  task automatic test_timer_single();
    write_ip(8'h00);
    write_ie(8'h82);
    pulse(5'b00010);
    checks++;
    if (int_pending !== 1'b0) begin
      errors++;
      $display("FAIL timer latency N+1: int_pending got %b want 0", int_pending);
    end
    expect_vec(8'h0B, 5'b00010);
    tick();
    checks++;
    if (int_pending !== 1'b1) begin
      errors++;
      $display("FAIL timer latency N+2: int_pending got %b want 1", int_pending);
    end
    service("timer");
    // Low level now in service: a second timer shot waits for RETI.
    pulse(5'b00010);
    no_request("timer nested low", 6);
    expect_vec(8'h0B, 5'b00010);
    do_reti();
    service("timer after reti");
    do_reti();
  endtask

  task automatic test_masking();
    write_ie(8'h02);
    pulse(5'b00010);
    no_request("masking EA=0", 6);
    write_ie(8'h82);
    expect_vec(8'h0B, 5'b00010);
    service("masking held pend");
    do_reti();
  endtask

  task automatic test_same_level_order();
    write_ip(8'h00);
    write_ie(8'h85);
    pulse(5'b00101);
    expect_vec(8'h03, 5'b00001);
    expect_vec(8'h13, 5'b00100);
    service("order first");
    do_reti();
    service("order second");
    do_reti();
  endtask

  task automatic test_preemption();
    write_ie(8'h87);
    write_ip(8'h04);
    pulse(5'b00010);
    expect_vec(8'h0B, 5'b00010);
    service("preempt low");
    pulse(5'b00100);
    expect_vec(8'h13, 5'b00100);
    service("preempt high");
    pulse(5'b00001);
    no_request("preempt both busy", 5);
    do_reti();
    no_request("preempt low busy", 5);
    expect_vec(8'h03, 5'b00001);
    do_reti();
    service("preempt deferred low");
    do_reti();
    write_ip(8'h00);
  endtask

  task automatic test_level_source();
    write_ie(8'h90);
    int_src = 5'b10000;
    expect_vec(8'h23, 5'b10000);
    service("serial level");
    no_request("serial in service", 4);
    int_src = 5'b00000;
    tick();
    do_reti();
    no_request("serial dropped", 5);
  endtask

  task automatic test_boundary_commit();
    write_ie(8'h82);
    inst_boundary = 1'b0;
    pulse(5'b00010);
    no_request("boundary low", 6);
    inst_boundary = 1'b1;
    tick();
    checks++;
    if (int_pending !== 1'b1) begin
      errors++;
      $display("FAIL boundary raise: int_pending got %b want 1", int_pending);
    end
    write_ie(8'h00);
    write_ip(8'h1F);
    checks++;
    if (int_pending !== 1'b1 || int_vector !== 8'h0B) begin
      errors++;
      $display("FAIL commit hold: pending %b vector %h want 1 0b", int_pending, int_vector);
    end
    expect_vec(8'h0B, 5'b00010);
    service("commit ack");
    do_reti();
    write_ip(8'h00);
  endtask

  task automatic test_async_reset();
    exp_t e;
    write_ie(8'h82);
    write_ip(8'h02);
    pulse(5'b00010);
    expect_vec(8'h0B, 5'b00010);
    wait_pending("reset setup");
    e = sb.pop_front();
    checks++;
    if (int_vector !== e.vec) begin
      errors++;
      $display("FAIL reset setup vector: got %h want %h", int_vector, e.vec);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (int_pending !== 1'b0 || ie_out !== 8'h00 || ip_out !== 8'h00) begin
      errors++;
      $display("FAIL async reset: pending %b ie %h ip %h want 0 00 00",
               int_pending, ie_out, ip_out);
    end
    tick();
    reset = 1'b0;
    tick();
    write_ie(8'h82);
    no_request("after reset no edge", 6);
    pulse(5'b00010);
    expect_vec(8'h0B, 5'b00010);
    service("after reset fresh edge");
    do_reti();
  endtask

  initial begin
    test_reset();
    test_regs();
    test_timer_single();
    test_masking();
    test_same_level_order();
    test_preemption();
    test_level_source();
    test_boundary_commit();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
